// File: rtl/seven_seg_scan.sv
// Time-multiplexed 7-segment driver with per-digit blink masking in adjust mode.
// Optional macro HEX_DECODE_EN: when defined, codes 10..15 show A,b,C,d,E,F; otherwise they blank the segments.
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    adj,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [IDX_W-1:0] r_idx;
    logic [REF_W-1:0] r_refCnt;
    logic [BLK_W-1:0] r_blinkCnt;
    logic             r_phase;

    logic [3:0]            w_code;
    logic [6:0]            w_segDecoded;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_anOn;

    assign w_code  = digits[{r_idx, 2'b00} +: 4];
    assign w_blank = adj & blink_mask[r_idx] & r_phase;
    assign w_anOn  = ~(NUM_DIGITS'(1) << r_idx);

    always_comb begin
        w_segDecoded = 7'h7F;
        case (w_code)
            4'd0:    w_segDecoded = 7'b1000000;
            4'd1:    w_segDecoded = 7'b1111001;
            4'd2:    w_segDecoded = 7'b0100100;
            4'd3:    w_segDecoded = 7'b0110000;
            4'd4:    w_segDecoded = 7'b0011001;
            4'd5:    w_segDecoded = 7'b0010010;
            4'd6:    w_segDecoded = 7'b0000010;
            4'd7:    w_segDecoded = 7'b1111000;
            4'd8:    w_segDecoded = 7'b0000000;
            4'd9:    w_segDecoded = 7'b0010000;
`ifdef HEX_DECODE_EN
            4'd10:   w_segDecoded = 7'b0001000;
            4'd11:   w_segDecoded = 7'b0000011;
            4'd12:   w_segDecoded = 7'b1000110;
            4'd13:   w_segDecoded = 7'b0100001;
            4'd14:   w_segDecoded = 7'b0000110;
            4'd15:   w_segDecoded = 7'b0001110;
`else
            default: w_segDecoded = 7'h7F;
`endif
        endcase
    end

    // Outputs are computed from the pre-edge scan index so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_refCnt   <= '0;
            r_blinkCnt <= '0;
            r_phase    <= 1'b0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            if (r_refCnt == REF_LAST) begin
                r_refCnt <= '0;
                r_idx    <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_refCnt <= r_refCnt + REF_W'(1);
            end

            if (!adj) begin
                r_blinkCnt <= '0;
                r_phase    <= 1'b0;
            end else if (r_blinkCnt == BLK_LAST) begin
                r_blinkCnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_blinkCnt <= r_blinkCnt + BLK_W'(1);
            end

            if (w_blank) begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= w_anOn;
                seg <= w_segDecoded;
                dp  <= ~dp_in[r_idx];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan against a cycle-count based reference model.
// Honours HEX_DECODE_EN in the model when the macro is defined for the build.
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BD = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   dp_in;
    logic [ND-1:0]   blink_mask;
    logic            adj;
    logic [6:0]      seg;
    logic            dp;
    logic [ND-1:0]   an;

    int checks = 0;
    int errors = 0;
    int edgesSinceReset = 0;
    int adjRun = 0;
    logic [6:0]    expSeg;
    logic          expDp;
    logic [ND-1:0] expAn;

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in),
        .blink_mask(blink_mask), .adj(adj), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [6:0] refSeg(input logic [3:0] code);
        logic [6:0] tbl [16];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
`ifdef HEX_DECODE_EN
                7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`else
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
        return tbl[code];
    endfunction

    // Slot = elapsed edges / REFRESH_DIV; blink phase = elapsed adj-high edges / BLINK_DIV, both mod 2/ND.
    task automatic modelEdge();
        int idx;
        int phase;
        if (!rst_n) begin
            expAn = '1; expSeg = 7'h7F; expDp = 1'b1;
            edgesSinceReset = 0;
            adjRun = 0;
        end else begin
            idx   = (edgesSinceReset / RD) % ND;
            phase = (adjRun / BD) % 2;
            if (adj && blink_mask[idx] && phase == 1) begin
                expAn = '1; expSeg = 7'h7F; expDp = 1'b1;
            end else begin
                expAn  = ~(ND'(1) << idx);
                expSeg = refSeg(digits[idx*4 +: 4]);
                expDp  = ~dp_in[idx];
            end
            edgesSinceReset++;
            adjRun = adj ? adjRun + 1 : 0;
        end
    endtask

    // mode 0: hold reset; 1: fixed 1234 scan; 2: blink with sparse digit changes; 3: everything random.
    task automatic applyStimulus(input int cycles, input int mode);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            case (mode)
                0: rst_n = 1'b0;
                1: begin
                    rst_n = 1'b1; adj = 1'b0; digits = 16'h1234; dp_in = 4'b0100;
                end
                2: begin
                    rst_n = 1'b1; adj = 1'b1;
                    if ($urandom_range(0, 7) == 0) digits = 16'($urandom);
                    if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
                end
                default: begin
                    rst_n = ($urandom_range(0, 59) != 0);
                    if ($urandom_range(0, 19) == 0) adj = ~adj;
                    if ($urandom_range(0, 3) == 0) digits = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) dp_in = 4'($urandom);
                    if ($urandom_range(0, 39) == 0) blink_mask = 4'($urandom);
                end
            endcase
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput("an", 32'(an), 32'(expAn));
            checkOutput("seg", 32'(seg), 32'(expSeg));
            checkOutput("dp", 32'(dp), 32'(expDp));
        end
    endtask

    initial begin
        rst_n = 1'b0; digits = 16'h1234; dp_in = '0; blink_mask = 4'b0011; adj = 1'b0;
        applyStimulus(3, 0);
        applyStimulus(40, 1);
        blink_mask = 4'b0011;
        applyStimulus(120, 2);
        applyStimulus(20, 1);
        digits = 16'hBA98;
        applyStimulus(40, 1);
        applyStimulus(600, 3);
        applyStimulus(2, 0);
        applyStimulus(20, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised, time-multiplexed 7-segment driver for the stopwatch front panel; next generation of the four-digit display block.
- Takes NUM_DIGITS packed 4-bit digit codes and scans one digit per refresh slot.
- Drives the shared active-low segment bus, decimal point and per-digit anode enables.
- Adds per-digit blink masking for adjust mode, driven by an internal blink timer, and registered glitch-free outputs.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
REFRESH_DIV, 100000, clk cycles each digit stays lit per scan slot (>=2)
BLINK_DIV, 50000000, clk cycles per blink half-period (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
digits  in  4*NUM_DIGITS  digit codes; digit i = digits[4*i+3:4*i]; digit 0 is rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
blink_mask  in  NUM_DIGITS  digits that blink while adj=1
adj  in  1  adjust mode enable
seg  out  7  segment drive, active-low; bit0=a .. bit6=g
dp  out  1  decimal point drive, active-low
an  out  NUM_DIGITS  anode enables, active-low, at most one low at any time

Behaviour:
- Reset (rst_n=0 at a clk edge): scan index=0; refresh counter=0; blink counter=0; blink phase=0; an=all 1; seg=7'h7F; dp=1. Reset mid-scan or mid-blink restarts from these values on the next edge.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. On the cycle it equals REFRESH_DIV-1, the scan index increments on that edge. From NUM_DIGITS-1 it wraps to 0; no out-of-range index is ever held.
- Outputs are registered and reflect the scan index with 1-cycle latency: the values computed from the index, digits, dp_in and blank condition in cycle t appear on seg, dp and an in cycle t+1.
  - Inputs are sampled every cycle; a change to digits shows within the current slot after 1 cycle.
- Decode, active-low, 0..9: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
- Codes 10..15 depend on HEX_DECODE_EN (see Optional Feature).
- dp = ~dp_in[index] unless the digit is blanked.
- Blink timer:
  - adj=0: blink counter and phase are held at 0.
  - adj=1: counter counts 0..BLINK_DIV-1; phase toggles on the wrap.
  - adj 0->1: the first half-period is visible (phase 0).
  - adj 1->0: phase is forced to 0 on the next edge.
- Blank condition = adj & blink_mask[index] & phase.
  - Blanked slot: an=all 1, seg=7'h7F, dp=1.
  - The scan still advances normally, so slot timing is unchanged.
- Exactly one an bit is low in every non-blanked, non-reset cycle.

Optional Feature:
HEX_DECODE_EN
- Defined: codes 10..15 display A,b,C,d,E,F = 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110.
- Undefined: codes 10..15 decode to blank (seg=7'h7F) while the anode is still driven and dp still follows dp_in.

Test Plan:
1. Reset then scan (NUM_DIGITS=4, REFRESH_DIV=4, digits=16'h1234, adj=0):
   - an=4'b1111, seg=7'h7F during reset.
   - After release, an steps 1110, 1101, 1011, 0111, 1110, every 4 cycles.
   - seg = 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001 in step with an.
2. Output latency: with REFRESH_DIV=4, change digits[3:0] from 4 to 8 mid-slot on digit 0 -> seg=7'b0000000 exactly 1 cycle later.
3. Blink (BLINK_DIV=16, adj=1, blink_mask=4'b0011):
   - Digits 0/1 lit for 16 cycles, blanked (an=1111 in their slots) for 16, repeating.
   - Digits 2/3 are never blanked.
   - Dropping adj -> digits 0/1 visible from the next edge.
4. Decimal point: dp_in=4'b0100 -> dp=0 only while an=4'b1011, else dp=1; with that digit blink-blanked, dp=1.
5. Hex decode: digit code 4'hA -> 7'b0001000 with HEX_DECODE_EN defined, 7'h7F without, and an still asserted in both cases.
6. Reset mid-operation: assert rst_n=0 in slot 2 during blink phase 1 -> next edge gives an=1111; after release, the scan restarts at digit 0 in blink phase 0.
